// File: rtl/counter.sv
// Free-running modulo-MODULUS up-counter advancing by STEP on every rising clk edge.
// Asynchronous active-low reset loads RESET_VAL; value comes straight from the count register.
module counter #(
    parameter int     WIDTH     = 4,
    parameter longint MODULUS   = 16,
    parameter longint RESET_VAL = 0,
    parameter longint STEP      = 1
) (
    output logic [WIDTH-1:0] value,
    input  logic             clk,
    input  logic             reset
);

    // Illegal configurations are reported while the design is elaborated.
    if ((WIDTH < 1) || (WIDTH > 32)) begin : g_bad_width
        $error("counter: WIDTH %0d outside 1..32", WIDTH);
    end
    if ((MODULUS < 64'sd2) || (MODULUS > (64'sd1 <<< WIDTH))) begin : g_bad_mod
        $error("counter: MODULUS %0d outside 2..2**WIDTH", MODULUS);
    end
    if ((RESET_VAL < 64'sd0) || (RESET_VAL >= MODULUS)) begin : g_bad_rst
        $error("counter: RESET_VAL %0d must be below MODULUS", RESET_VAL);
    end
    if ((STEP < 64'sd0) || (STEP >= MODULUS)) begin : g_bad_step
        $error("counter: STEP %0d must be below MODULUS", STEP);
    end

    localparam logic [WIDTH:0]   MOD_C   = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]   STEP_C  = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] RESET_C = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;
    logic [WIDTH:0]   sum_s;

    // Next count: the extra sum bit keeps the carry when MODULUS equals 2**WIDTH.
    always_comb begin
        sum_s   = {1'b0, value_q} + STEP_C;
        value_d = WIDTH'(sum_s);
        if (sum_s >= MOD_C) begin
            value_d = WIDTH'(sum_s - MOD_C);
        end else begin
            value_d = WIDTH'(sum_s);
        end
    end

    // Count register; reset takes effect immediately and overrides any clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value_q <= RESET_C;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: tb/tb_counter.sv
// Directed bench for counter: table of reset/count vectors plus hand-written reset corner cases,
// run on the default configuration, a MODULUS=10/STEP=3 instance and a 3-bit modulo-8 instance.
module tb_counter;

    logic       clk;
    logic       reset;
    logic [3:0] val_def;
    logic [3:0] val_m10;
    logic [2:0] val_w3;

    int checks;
    int errors;

    counter u_def (.value(val_def), .clk(clk), .reset(reset));
    counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0), .STEP(3))
        u_m10 (.value(val_m10), .clk(clk), .reset(reset));
    counter #(.WIDTH(3), .MODULUS(8), .RESET_VAL(0), .STEP(1))
        u_w3 (.value(val_w3), .clk(clk), .reset(reset));

    typedef struct {
        logic       rst_in;
        logic [3:0] exp_def;
        logic [3:0] exp_m10;
        logic [2:0] exp_w3;
    } vec_t;

    vec_t vecs[27];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running required done");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [3:0] e_def,
                             input logic [3:0] e_m10, input logic [2:0] e_w3);
        check({name, "/def"}, {28'd0, val_def}, {28'd0, e_def});
        check({name, "/m10"}, {28'd0, val_m10}, {28'd0, e_m10});
        check({name, "/w3"},  {29'd0, val_w3},  {29'd0, e_w3});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // 10 edges held in reset
        for (int i = 0; i < 10; i++) vecs[i] = '{1'b0, 4'd0, 4'd0, 3'd0};
        // 17 counting edges after release
        vecs[10] = '{1'b1, 4'd1,  4'd3, 3'd1};
        vecs[11] = '{1'b1, 4'd2,  4'd6, 3'd2};
        vecs[12] = '{1'b1, 4'd3,  4'd9, 3'd3};
        vecs[13] = '{1'b1, 4'd4,  4'd2, 3'd4};
        vecs[14] = '{1'b1, 4'd5,  4'd5, 3'd5};
        vecs[15] = '{1'b1, 4'd6,  4'd8, 3'd6};
        vecs[16] = '{1'b1, 4'd7,  4'd1, 3'd7};
        vecs[17] = '{1'b1, 4'd8,  4'd4, 3'd0};
        vecs[18] = '{1'b1, 4'd9,  4'd7, 3'd1};
        vecs[19] = '{1'b1, 4'd10, 4'd0, 3'd2};
        vecs[20] = '{1'b1, 4'd11, 4'd3, 3'd3};
        vecs[21] = '{1'b1, 4'd12, 4'd6, 3'd4};
        vecs[22] = '{1'b1, 4'd13, 4'd9, 3'd5};
        vecs[23] = '{1'b1, 4'd14, 4'd2, 3'd6};
        vecs[24] = '{1'b1, 4'd15, 4'd5, 3'd7};
        vecs[25] = '{1'b1, 4'd0,  4'd8, 3'd0};
        vecs[26] = '{1'b1, 4'd1,  4'd1, 3'd1};

        reset = 1'b0;
        #1;
        check_all("async_reset_at_start", 4'd0, 4'd0, 3'd0);

        for (int i = 0; i < 27; i++) begin
            reset = vecs[i].rst_in;
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].exp_def, vecs[i].exp_m10, vecs[i].exp_w3);
        end

        // Mid-cycle reset pulse at value 7 with no clock edge inside it
        for (int i = 0; i < 6; i++) tick();
        check("pulse_pre7", {28'd0, val_def}, 32'd7);
        #1;
        reset = 1'b0;
        #1;
        check_all("pulse_async", 4'd0, 4'd0, 3'd0);
        #4;
        reset = 1'b1;
        #1;
        check("pulse_release_nochange", {28'd0, val_def}, 32'd0);
        tick();
        check_all("pulse_first_edge", 4'd1, 4'd3, 3'd1);

        // Reset asserted on the same timestep as a rising edge at value 9
        for (int i = 0; i < 7; i++) tick();
        check("coinc_pre9", {28'd0, val_def}, 32'd8);
        @(posedge clk);
        reset = 1'b0;
        #1;
        check_all("coinc_reset_wins", 4'd0, 4'd0, 3'd0);
        tick();
        tick();
        check_all("coinc_hold", 4'd0, 4'd0, 3'd0);
        reset = 1'b1;
        tick();
        check_all("coinc_restart", 4'd1, 4'd3, 3'd1);
        tick();
        check_all("coinc_restart2", 4'd2, 4'd6, 3'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
